// File: rtl/gcd_core.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_core
//  Brief    : Iterative subtract-and-compare GCD engine with clock enable.
//             Operands are captured on a start pulse; the larger working value
//             is reduced by the smaller until they match. A zero operand
//             short-circuits straight to completion with result = a | b.
//             Optional feature macro: GCD_ERR_FLAG_EN adds an 'err' output
//             flagging a zero operand on the completed operation.
//  Revision : 1.0 - initial release
// ============================================================================
module gcd_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
`ifdef GCD_ERR_FLAG_EN
  output logic             err,
`endif
  output logic [WIDTH-1:0] iter
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_x, w_x_nxt;
  logic [WIDTH-1:0] r_y, w_y_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [WIDTH-1:0] r_iter, w_iter_nxt;
`ifdef GCD_ERR_FLAG_EN
  logic             r_err, w_err_nxt;
`endif

  // State and datapath registers; clk_en low freezes everything, rst wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_x      <= c_zero;
      r_y      <= c_zero;
      r_result <= c_zero;
      r_iter   <= c_zero;
`ifdef GCD_ERR_FLAG_EN
      r_err    <= 1'b0;
`endif
    end else if (clk_en) begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_result <= w_result_nxt;
      r_iter   <= w_iter_nxt;
`ifdef GCD_ERR_FLAG_EN
      r_err    <= w_err_nxt;
`endif
    end
  end

  // Next-state and datapath update; every register holds unless a state acts on it.
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_result_nxt = r_result;
    w_iter_nxt   = r_iter;
`ifdef GCD_ERR_FLAG_EN
    w_err_nxt    = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_x_nxt    = a;
          w_y_nxt    = b;
          w_iter_nxt = c_zero;
`ifdef GCD_ERR_FLAG_EN
          w_err_nxt  = 1'b0;
`endif
          if ((a == c_zero) || (b == c_zero)) begin
            // gcd(0,n) = n and gcd(0,0) = 0 both fall out of the OR.
            w_result_nxt = a | b;
            w_state_nxt  = S_DONE;
`ifdef GCD_ERR_FLAG_EN
            w_err_nxt    = 1'b1;
`endif
          end else begin
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (r_x == r_y) begin
          w_result_nxt = r_x;
          w_state_nxt  = S_DONE;
        end else if (r_x > r_y) begin
          w_x_nxt    = r_x - r_y;
          w_iter_nxt = r_iter + c_one;
        end else begin
          w_y_nxt    = r_y - r_x;
          w_iter_nxt = r_iter + c_one;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs decode the registered state only, so start never reaches them.
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign iter   = r_iter;
`ifdef GCD_ERR_FLAG_EN
  assign err    = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_core
//  Brief    : Self-checking bench for gcd_core (WIDTH = 8). A cycle-level
//             transaction model predicts busy/done/result/iter/err from the
//             operand values and enabled-edge counts; directed cases pin the
//             model with hand-computed literals, then random traffic follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_core;

  localparam int W = 8;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         clk_en = 1'b1;
  logic         start  = 1'b0;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic [W-1:0] iter;
`ifdef GCD_ERR_FLAG_EN
  logic         err;
`endif

  gcd_core #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done),
    .busy   (busy),
`ifdef GCD_ERR_FLAG_EN
    .err    (err),
`endif
    .iter   (iter)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: gcd and number of subtraction steps by plain arithmetic.
  function automatic void ref_gcd(input int x0, input int y0, output int g, output int s);
    int x = x0;
    int y = y0;
    s = 0;
    while (x != y) begin
      if (x > y) x = x - y;
      else       y = y - x;
      s++;
    end
    g = x;
  endfunction

  // Transaction model: tracks how many enabled edges remain until completion.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_err  = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_iter   = '0;
  logic [W-1:0] p_result = '0;
  logic [W-1:0] p_iter   = '0;
  int           g_v, s_v;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_result = '0; m_iter = '0;
    end else if (clk_en) begin
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_result = p_result;
          m_iter   = p_iter;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_iter = '0;
        m_err  = 1'b0;
        if (a == '0 || b == '0) begin
          m_done   = 1'b1;
          m_result = a | b;
          m_err    = 1'b1;
        end else begin
          ref_gcd(int'(a), int'(b), g_v, s_v);
          p_result = W'(g_v);
          p_iter   = W'(s_v);
          m_left   = s_v + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model; iter is only defined outside CALC.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy",   busy,   m_busy);
      check("done",   done,   m_done);
      check("result", result, m_result);
      if (!m_busy || m_done) check("iter", iter, m_iter);
`ifdef GCD_ERR_FLAG_EN
      check("err", err, m_err);
`endif
    end
  end

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", done, 1);
  endtask

  task automatic op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                    input int er, input int ei, input int elat);
    int n;
    start_op(av, bv);
    wait_done(1, n);
    check({name, "_lat"},    n,      elat);
    check({name, "_result"}, result, er);
    check({name, "_iter"},   iter,   ei);
    @(negedge clk);
    check({name, "_done1"},  done,   0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_result", result, 0);
    check("rst_iter",   iter,   0);
    rst = 1'b0;

    op("g12_8", 8'd12, 8'd8, 4, 2, 4);
    op("g7_7",  8'd7,  8'd7, 7, 0, 2);
    op("g0_5",  8'd0,  8'd5, 5, 0, 1);
`ifdef GCD_ERR_FLAG_EN
    check("g0_5_err", err, 1);
`endif
    op("g0_0",  8'd0,  8'd0, 0, 0, 1);
    op("g9_6",  8'd9,  8'd6, 3, 2, 4);

    // Long run with an ignored start pulse in the middle.
    start_op(8'd255, 8'd1);
    repeat (10) @(negedge clk);
    a = 8'd9; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("long_busy_mid", busy, 1);
    wait_done(12, n);
    check("long_lat",    n,      256);
    check("long_result", result, 1);
    check("long_iter",   iter,   254);

    // Clock enable held low for three cycles during CALC.
    start_op(8'd12, 8'd8);
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("freeze_iter", iter, 0);
      check("freeze_busy", busy, 1);
    end
    clk_en = 1'b1;
    wait_done(4, n);
    check("freeze_lat",    n,      7);
    check("freeze_result", result, 4);
    check("freeze_iter2",  iter,   2);

    // Reset two cycles into CALC aborts with no done pulse.
    start_op(8'd255, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",   busy,   0);
    check("abort_result", result, 0);
    check("abort_iter",   iter,   0);
    check("abort_done",   done,   0);
    repeat (5) begin
      @(negedge clk);
      check("abort_nodone", done, 0);
    end
    op("after_rst", 8'd12, 8'd8, 4, 2, 4);

    // Random traffic, including clock-enable gaps, zero operands and resets.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      clk_en = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 2) == 0);
      a      = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
      b      = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, (k % 2 == 0) ? 255 : 40));
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; clk_en = 1'b1;
    repeat (300) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gcd_core.md
GCD_CORE -- requirements
Module: gcd_core

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand, result and iteration-counter width.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port clk_en, input, 1: clock enable; when low, state is frozen.
REQ-005 SHALL have port start, input, 1: single-cycle request pulse, driven by the upstream rising-edge detector.
REQ-006 SHALL have port a, input, WIDTH: first operand, unsigned.
REQ-007 SHALL have port b, input, WIDTH: second operand, unsigned.
REQ-008 SHALL have port result, output, WIDTH: GCD of the last captured operands.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse, feeding the downstream set/clear flag.
REQ-010 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-011 SHALL have port iter, output, WIDTH: number of subtraction steps used for the last result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE; all transitions occur only on edges where clk_en=1.
REQ-013 In IDLE with start=1, SHALL capture a into x and b into y, clear iter and go to CALC.
REQ-014 If a=0 or b=0 at capture, SHALL set result=a|b (so gcd(0,0)=0) and go directly to DONE, skipping CALC.
REQ-015 In CALC with x=y, SHALL load result=x and go to DONE.
REQ-016 In CALC with x>y, SHALL set x=x-y; with x<y, SHALL set y=y-x; each step SHALL increment iter by 1.
REQ-017 In DONE, SHALL drive done=1 and return to IDLE on the next enabled edge.
REQ-018 Latency: with S subtractions, done SHALL be high after S+2 enabled edges, counting the start-capture edge; the zero-operand case SHALL take 1 edge.
REQ-019 Arithmetic SHALL be unsigned WIDTH-bit; no subtraction can underflow because the larger value is always reduced.
REQ-020 start while busy=1 SHALL be ignored, and operands SHALL NOT be re-sampled.
REQ-021 With clk_en=0, all registers SHALL hold; done SHALL stay high if already high, and still counts as a single enabled cycle.
REQ-022 result and iter SHALL stay stable from DONE until the next start capture.
REQ-023 busy SHALL be a registered-state decode, with no combinational path from start.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE and set result=0, iter=0, done=0, busy=0, and err=0 when present.
REQ-025 rst SHALL take priority over clk_en and start, and SHALL abort any CALC in progress with no done pulse.

Configuration
REQ-026 Macro GCD_ERR_FLAG_EN defined: SHALL add output port err, 1 bit, set with done when either captured operand is 0, and cleared on the next start capture or reset.
REQ-027 Macro GCD_ERR_FLAG_EN undefined: err port and its logic SHALL be absent; zero operands SHALL still be handled per REQ-014.

Verification
REQ-028 a=12, b=8, start pulse -> result=4, iter=2, done high 4 edges after the start edge, for exactly 1 cycle.
REQ-029 a=7, b=7 -> result=7, iter=0, done after 2 edges; a=0, b=5 -> result=5, done after 1 edge, err=1 (macro defined).
REQ-030 WIDTH=8, a=255, b=1 -> result=1, iter=254, busy high throughout; start re-pulsed mid-run with a=9 -> ignored, result still 1.
REQ-031 a=12, b=8, clk_en held low for 3 cycles during CALC -> x, y and iter frozen; result=4, done after 4 enabled edges.
REQ-032 rst asserted 2 cycles into CALC of 255,1 -> next edge IDLE, result=0, iter=0, no done; a new start then completes normally.
